// File: rtl/multi_counter_dispatcher.sv
// Pops {id, time} entries from the queue FIFO and loads each into one idle service counter.
// Fixed-priority or round-robin selection, post-load reservation, zero-time discard, statistics.
module multi_counter_dispatcher #(
    parameter int unsigned NUM_CTR  = 3,
    parameter int unsigned ID_W     = 4,
    parameter int unsigned TIME_W   = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned RESV_MAX = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      rr_mode,
    input  logic                      empty,
    input  logic [ID_W-1:0]           q_id,
    input  logic [TIME_W-1:0]         q_time,
    input  logic [NUM_CTR-1:0]        busy,
    output logic                      re,
    output logic [NUM_CTR-1:0]        ld,
    output logic [NUM_CTR*ID_W-1:0]   d_id,
    output logic [NUM_CTR*TIME_W-1:0] d_time,
    output logic [CNT_W-1:0]          n_disp,
    output logic [CNT_W-1:0]          n_drop,
    output logic                      all_busy
);

    localparam int unsigned      PTR_W     = $clog2(NUM_CTR);
    localparam int unsigned      TMR_W     = $clog2(RESV_MAX + 1);
    localparam logic [PTR_W:0]   NUM_CTR_W = (PTR_W + 1)'(NUM_CTR);
    localparam logic [TMR_W-1:0] RESV_INIT = TMR_W'(RESV_MAX);

    typedef enum logic {StIdle, StCool} state_e;

    state_e             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   sel;
    logic [PTR_W:0]     idx;
    logic               sel_ok;
    logic [NUM_CTR-1:0] resv;
    logic [NUM_CTR-1:0] avail;
    logic [NUM_CTR-1:0] ld_set;
    logic [TMR_W-1:0]   resv_tmr [NUM_CTR];
    logic               head_valid;
    logic               do_drop;
    logic               do_load;
    logic               do_stall;

    // Scan starts at ptr in round-robin mode and at 0 in fixed mode; first hit wins.
    always_comb begin
        avail  = ~busy & ~resv;
        sel    = '0;
        sel_ok = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_CTR; i++) begin
            idx = rr_mode ? ({1'b0, ptr} + (PTR_W + 1)'(i)) : (PTR_W + 1)'(i);
            if (idx >= NUM_CTR_W) idx = idx - NUM_CTR_W;
            if (!sel_ok && avail[idx[PTR_W-1:0]]) begin
                sel_ok = 1'b1;
                sel    = idx[PTR_W-1:0];
            end
        end
    end

    assign head_valid = (state == StIdle) && en && !empty;
    assign do_drop    = head_valid && (q_time == '0);
    assign do_load    = head_valid && (q_time != '0) && sel_ok;
    assign do_stall   = head_valid && (q_time != '0) && !sel_ok;
    assign ld_set     = do_load ? (NUM_CTR'(1) << sel) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            ptr      <= '0;
            re       <= 1'b0;
            ld       <= '0;
            d_id     <= '0;
            d_time   <= '0;
            n_disp   <= '0;
            n_drop   <= '0;
            all_busy <= 1'b0;
        end else begin
            re       <= do_drop | do_load;
            ld       <= ld_set;
            all_busy <= do_stall;
            if (do_drop && n_drop != '1) n_drop <= n_drop + 1'b1;
            if (do_load) begin
                d_id[sel*ID_W +: ID_W]       <= q_id;
                d_time[sel*TIME_W +: TIME_W] <= q_time;
                if (n_disp != '1) n_disp <= n_disp + 1'b1;
                ptr <= ({1'b0, sel} == NUM_CTR_W - 1'b1) ? '0 : sel + 1'b1;
            end
            // COOL skips one decision: empty and the head are stale right after a pop.
            unique case (state)
                StIdle:  if (do_drop || do_load) state <= StCool;
                StCool:  state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

    // Reservation lasts until busy is seen or the timer runs out after the load cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resv <= '0;
            for (int k = 0; k < NUM_CTR; k++) resv_tmr[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_CTR; k++) begin
                if (ld_set[k]) begin
                    resv[k]     <= 1'b1;
                    resv_tmr[k] <= RESV_INIT;
                end else if (resv[k]) begin
                    if (busy[k] || resv_tmr[k] == '0) resv[k] <= 1'b0;
                    else resv_tmr[k] <= resv_tmr[k] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_counter_dispatcher.sv
// Bench for multi_counter_dispatcher: FIFO model doubles as scoreboard of expected targets.
// A second instance with 2-bit statistics covers counter saturation.
module tb_multi_counter_dispatcher;

    localparam int NUM_CTR  = 3;
    localparam int ID_W     = 4;
    localparam int TIME_W   = 4;
    localparam int CNT_W    = 8;
    localparam int RESV_MAX = 3;
    localparam int HOLD     = 2;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [TIME_W-1:0] tm;
        int                ctr;
    } ent_t;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      en = 1'b1;
    logic                      rr_mode = 1'b0;
    logic                      empty = 1'b1;
    logic [ID_W-1:0]           q_id = '0;
    logic [TIME_W-1:0]         q_time = '0;
    logic [NUM_CTR-1:0]        busy = '0;
    logic                      re;
    logic [NUM_CTR-1:0]        ld;
    logic [NUM_CTR*ID_W-1:0]   d_id;
    logic [NUM_CTR*TIME_W-1:0] d_time;
    logic [CNT_W-1:0]          n_disp;
    logic [CNT_W-1:0]          n_drop;
    logic                      all_busy;
    logic                      s_re;
    logic [NUM_CTR-1:0]        s_ld;
    logic [NUM_CTR*ID_W-1:0]   s_d_id;
    logic [NUM_CTR*TIME_W-1:0] s_d_time;
    logic [1:0]                s_n_disp;
    logic [1:0]                s_n_drop;
    logic                      s_all_busy;

    int   tests_run = 0;
    int   tests_fail = 0;
    int   cyc = 0;
    int   last_re = -1;
    int   gap_exp = 2;
    bit   chk_gap = 1'b0;
    bit   auto_busy = 1'b0;
    int   bz_cnt [NUM_CTR];
    bit   pend [NUM_CTR];
    ent_t sb [$];

    multi_counter_dispatcher #(
        .NUM_CTR(NUM_CTR), .ID_W(ID_W), .TIME_W(TIME_W), .CNT_W(CNT_W), .RESV_MAX(RESV_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rr_mode(rr_mode), .empty(empty), .q_id(q_id),
        .q_time(q_time), .busy(busy), .re(re), .ld(ld), .d_id(d_id), .d_time(d_time),
        .n_disp(n_disp), .n_drop(n_drop), .all_busy(all_busy)
    );

    multi_counter_dispatcher #(
        .NUM_CTR(NUM_CTR), .ID_W(ID_W), .TIME_W(TIME_W), .CNT_W(2), .RESV_MAX(RESV_MAX)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .rr_mode(rr_mode), .empty(empty), .q_id(q_id),
        .q_time(q_time), .busy(busy), .re(s_re), .ld(s_ld), .d_id(s_d_id), .d_time(s_d_time),
        .n_disp(s_n_disp), .n_drop(s_n_drop), .all_busy(s_all_busy)
    );

    always #5 clk = ~clk;

    task automatic drive_head();
        empty = (sb.size() == 0);
        if (sb.size() != 0) begin
            q_id   = sb[0].id;
            q_time = sb[0].tm;
        end else begin
            q_id   = '0;
            q_time = '0;
        end
    endtask

    task automatic push(input logic [ID_W-1:0] id, input logic [TIME_W-1:0] tm, input int ctr);
        ent_t e;
        e.id  = id;
        e.tm  = tm;
        e.ctr = ctr;
        sb.push_back(e);
        drive_head();
    endtask

    // One clock: sample outputs just after the edge, score any pop, update busy and FIFO head.
    task automatic step();
        ent_t               e;
        logic [NUM_CTR-1:0] exp_ld;
        @(posedge clk);
        #1;
        cyc++;
        if (auto_busy) begin
            for (int k = 0; k < NUM_CTR; k++) begin
                if (pend[k]) begin
                    bz_cnt[k] = HOLD;
                    pend[k]   = 1'b0;
                end else if (bz_cnt[k] > 0) begin
                    bz_cnt[k]--;
                end
                busy[k] = (bz_cnt[k] != 0);
                if (ld[k] === 1'b1) pend[k] = 1'b1;
            end
        end
        if (re === 1'b1) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_fail++;
                $display("FAIL re_unexpected: re=1 at cycle %0d, no entry queued", cyc);
            end else begin
                e      = sb.pop_front();
                exp_ld = (e.ctr < 0) ? '0 : (NUM_CTR'(1) << e.ctr);
                tests_run++;
                if (ld !== exp_ld) begin
                    tests_fail++;
                    $display("FAIL ld_target: id=%0d got ld=%b expected %b", e.id, ld, exp_ld);
                end
                if (e.ctr >= 0) begin
                    tests_run++;
                    if (d_id[e.ctr*ID_W +: ID_W] !== e.id ||
                        d_time[e.ctr*TIME_W +: TIME_W] !== e.tm) begin
                        tests_fail++;
                        $display("FAIL slice_data: ctr %0d got id=%0d time=%0d expected %0d/%0d",
                                 e.ctr, d_id[e.ctr*ID_W +: ID_W],
                                 d_time[e.ctr*TIME_W +: TIME_W], e.id, e.tm);
                    end
                end
                if (chk_gap && last_re >= 0) begin
                    tests_run++;
                    if (cyc - last_re != gap_exp) begin
                        tests_fail++;
                        $display("FAIL re_spacing: got %0d cycles expected %0d",
                                 cyc - last_re, gap_exp);
                    end
                end
                last_re = cyc;
            end
        end else if (ld !== '0) begin
            tests_run++;
            tests_fail++;
            $display("FAIL ld_without_re: ld=%b re=%b", ld, re);
        end
        drive_head();
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        sb.delete();
        drive_head();
        busy      = '0;
        en        = 1'b1;
        auto_busy = 1'b0;
        chk_gap   = 1'b0;
        last_re   = -1;
        for (int k = 0; k < NUM_CTR; k++) begin
            bz_cnt[k] = 0;
            pend[k]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests_run++;
        if ({re, ld, all_busy} !== '0) begin
            tests_fail++;
            $display("FAIL reset_pulses: got re=%b ld=%b all_busy=%b expected 0", re, ld, all_busy);
        end
        tests_run++;
        if ({d_id, d_time, n_disp, n_drop} !== '0) begin
            tests_fail++;
            $display("FAIL reset_data: got d_id=%h d_time=%h n_disp=%0d n_drop=%0d expected 0",
                     d_id, d_time, n_disp, n_drop);
        end
    endtask

    task automatic test_fixed_burst();
        do_reset();
        rr_mode = 1'b0;
        chk_gap = 1'b1;
        gap_exp = 2;
        push(4'd1, 4'd5, 0);
        push(4'd2, 4'd3, 1);
        push(4'd3, 4'd4, 2);
        drain(10);
        tests_run++;
        if (n_disp !== 8'd3) begin
            tests_fail++;
            $display("FAIL fixed_n_disp: got %0d expected 3", n_disp);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        rr_mode   = 1'b1;
        auto_busy = 1'b1;
        push(4'd1, 4'd1, 0);
        push(4'd2, 4'd2, 1);
        push(4'd3, 4'd3, 2);
        push(4'd4, 4'd4, 0);
        drain(12);
        repeat (10) step();
        push(4'd5, 4'd5, 1); // ptr should have advanced to 1
        drain(4);
        do_reset();
        rr_mode   = 1'b0;
        auto_busy = 1'b1;
        push(4'd1, 4'd1, 0);
        push(4'd2, 4'd2, 1);
        push(4'd3, 4'd3, 0);
        push(4'd4, 4'd4, 1);
        drain(12);
    endtask

    task automatic test_zero_time();
        do_reset();
        chk_gap = 1'b1;
        gap_exp = 2;
        push(4'd9, 4'd0, -1);
        push(4'd7, 4'd2, 0);
        drain(8);
        tests_run++;
        if (n_drop !== 8'd1 || n_disp !== 8'd1) begin
            tests_fail++;
            $display("FAIL zero_time_counts: got drop=%0d disp=%0d expected 1/1", n_drop, n_disp);
        end
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0;
        push(4'd3, 4'd3, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            tests_run++;
            if (re !== 1'b0) begin
                tests_fail++;
                $display("FAIL enable_gate: got re=%b expected 0", re);
            end
        end
        en = 1'b1;
        drain(4);
    endtask

    task automatic test_all_busy();
        do_reset();
        busy = 3'b111;
        push(4'd4, 4'd2, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (re !== 1'b0 || all_busy !== 1'b1) begin
                tests_fail++;
                $display("FAIL all_busy_hold: got re=%b all_busy=%b expected 0/1", re, all_busy);
            end
        end
        busy = 3'b101;
        step();
        tests_run++;
        if (all_busy !== 1'b0 || ld !== 3'b010) begin
            tests_fail++;
            $display("FAIL all_busy_release: got all_busy=%b ld=%b expected 0/010", all_busy, ld);
        end
        tests_run++;
        if (sb.size() != 0) begin
            tests_fail++;
            $display("FAIL all_busy_pop: got %0d queued expected 0", sb.size());
        end
        busy = '0;
    endtask

    task automatic test_reservation();
        do_reset();
        busy    = 3'b011;
        chk_gap = 1'b1;
        gap_exp = RESV_MAX + 2; // load cycle plus reserved cycles, then a fresh decision
        push(4'd6, 4'd6, 2);
        push(4'd8, 4'd7, 2);
        drain(12);
        busy = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        rr_mode = 1'b1;
        push(4'd5, 4'd6, 0);
        step();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (re !== 1'b0 || ld !== '0) begin
            tests_fail++;
            $display("FAIL async_abort: got re=%b ld=%b expected 0/000", re, ld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (n_disp !== '0) begin
            tests_fail++;
            $display("FAIL async_n_disp: got %0d expected 0", n_disp);
        end
        push(4'd9, 4'd1, 0); // ptr back at 0
        drain(4);
    endtask

    task automatic test_saturation();
        do_reset();
        rr_mode = 1'b0;
        push(4'd1, 4'd1, 0);
        push(4'd2, 4'd2, 1);
        push(4'd3, 4'd3, 2);
        push(4'd4, 4'd4, 0);
        push(4'd5, 4'd5, 1);
        drain(16);
        tests_run++;
        if (n_disp !== 8'd5) begin
            tests_fail++;
            $display("FAIL sat_wide: got %0d expected 5", n_disp);
        end
        tests_run++;
        if (s_n_disp !== 2'd3) begin
            tests_fail++;
            $display("FAIL sat_narrow: got %0d expected 3", s_n_disp);
        end
    endtask

    initial begin
        test_reset();
        test_fixed_burst();
        test_round_robin();
        test_zero_time();
        test_enable();
        test_all_busy();
        test_reservation();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
